// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous RAM between the instruction-fetch port
//   (IF, read-only) and the data-memory port (DM, read/write). DM normally has
//   priority; IF is force-granted after STARVE_LIMIT consecutive denied cycles.
//   Each granted read is tagged so the one-cycle-latency RAM data is flagged
//   valid to its owner in the following cycle.
//
// Ports
//   clk_i, n_rst              clock, asynchronous active-low reset
//   if_req_i / if_addr_i      fetch read request and byte address
//   if_gnt_o                  fetch accepted this cycle (combinational)
//   if_rvalid_o / if_rdata_o  fetch read response
//   dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i
//                             data request, write flag, byte enables, address, data
//   dm_gnt_o                  data accepted this cycle (combinational)
//   dm_rvalid_o / dm_rdata_o  data read response
//   ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_rdata_i
//                             RAM side; ram_rdata_i is valid one cycle after a read
//
// DATA_W must be 32 (four byte lanes); STARVE_LIMIT must lie in 1..15.

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              n_rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_be_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-3:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic {DM_PRI, IF_FORCE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_DM} tag_t;

  state_t     state_reg, state_next;
  logic [3:0] starve_cnt_reg, starve_cnt_next;
  tag_t       tag_reg, tag_next;
  logic       if_gnt, dm_gnt;

  // Word addressing: the byte-offset bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[1:0], dm_addr_i[1:0]};

  // State register.
  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= DM_PRI;
      starve_cnt_reg <= '0;
      tag_reg        <= TAG_NONE;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      tag_reg        <= tag_next;
    end
  end

  // Next-state logic. The counter counts cycles IF has waited; the switch to
  // IF_FORCE happens on the edge where the count reaches the limit, so IF is
  // granted in the cycle right after its STARVE_LIMIT-th denial.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    case (state_reg)
      DM_PRI: begin
        if (if_req_i && !if_gnt) starve_cnt_next = starve_cnt_reg + 4'd1;
        else                     starve_cnt_next = '0;
        if (starve_cnt_next == 4'(STARVE_LIMIT)) state_next = IF_FORCE;
      end
      IF_FORCE: begin
        // One forced slot only, whether or not IF still requests.
        state_next      = DM_PRI;
        starve_cnt_next = '0;
      end
    endcase

    // Only reads expect a response; DM writes leave the tag empty.
    tag_next = TAG_NONE;
    if (if_gnt)                 tag_next = TAG_IF;
    else if (dm_gnt && !dm_we_i) tag_next = TAG_DM;
  end

  // Output logic. Grants are gated by reset so nothing is issued to the RAM
  // while n_rst is low.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (n_rst) begin
      case (state_reg)
        DM_PRI: begin
          if (dm_req_i)      dm_gnt = 1'b1;
          else if (if_req_i) if_gnt = 1'b1;
        end
        IF_FORCE: if_gnt = if_req_i;
      endcase
    end

    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (dm_gnt) begin
      ram_addr_o = dm_addr_i[ADDR_W-1:2];
      if (dm_we_i) ram_wdata_o = dm_wdata_i;
    end else if (if_gnt) begin
      ram_addr_o = if_addr_i[ADDR_W-1:2];
    end
  end

  assign if_gnt_o = if_gnt;
  assign dm_gnt_o = dm_gnt;
  assign ram_en_o = if_gnt | dm_gnt;

  // Per-lane write enables; a write with no lanes enabled still occupies a
  // RAM cycle but modifies nothing.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_we_lane
      assign ram_we_o[gi] = dm_gnt & dm_we_i & dm_be_i[gi];
    end
  endgenerate

  assign if_rvalid_o = (tag_reg == TAG_IF);
  assign dm_rvalid_o = (tag_reg == TAG_DM);
  assign if_rdata_o  = n_rst ? ram_rdata_i : '0;
  assign dm_rdata_o  = n_rst ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a small byte-writable RAM with one-cycle read
// latency sits on the RAM port. Directed stimulus checks grants and RAM drive
// in the grant cycle and queues the expected read responses; a monitor pops
// and compares them whenever an rvalid appears.

module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        n_rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [3:0]  dm_be_i = '0;
  logic [31:0] dm_addr_i = '0, dm_wdata_i = '0;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [29:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = 32'h5A5A_5A5A;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .n_rst(n_rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM environment
  logic [31:0] mem [0:255];
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o[7:0]];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o[7:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  typedef struct { logic [31:0] data; int due; } resp_t;
  resp_t if_q[$];
  resp_t dm_q[$];

  // Response monitor
  always @(negedge clk_i) begin
    resp_t e;
    if (if_rvalid_o && dm_rvalid_o) check("rvalid_exclusive", 32'(if_rvalid_o & dm_rvalid_o), 32'd0);
    if (if_rvalid_o) begin
      if (if_q.size() == 0) check("if_rvalid_unexpected", 32'(if_rvalid_o), 32'd0);
      else begin
        e = if_q.pop_front();
        check("if_rdata", if_rdata_o, e.data);
        check("if_rvalid_cycle", 32'(cyc), 32'(e.due));
        $display("cycle %0d IF response data=%h", cyc, if_rdata_o);
      end
    end
    if (dm_rvalid_o) begin
      if (dm_q.size() == 0) check("dm_rvalid_unexpected", 32'(dm_rvalid_o), 32'd0);
      else begin
        e = dm_q.pop_front();
        check("dm_rdata", dm_rdata_o, e.data);
        check("dm_rvalid_cycle", 32'(cyc), 32'(e.due));
        $display("cycle %0d DM response data=%h", cyc, dm_rdata_o);
      end
    end
  end

  // One request cycle: drive, let the combinational grant settle, compare,
  // and queue the response expected one cycle later.
  task automatic issue(input string name,
                       input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic exp_if, input logic exp_dm,
                       input logic [29:0] exp_addr, input logic [31:0] exp_rd);
    resp_t r;
    @(posedge clk_i); #1;
    if_req_i = ir; if_addr_i = ia;
    dm_req_i = dr; dm_we_i = dwe; dm_be_i = be; dm_addr_i = da; dm_wdata_i = wd;
    #1;
    check({name, "/if_gnt"}, 32'(if_gnt_o), 32'(exp_if));
    check({name, "/dm_gnt"}, 32'(dm_gnt_o), 32'(exp_dm));
    check({name, "/ram_en"}, 32'(ram_en_o), 32'(exp_if | exp_dm));
    check({name, "/ram_we"}, 32'(ram_we_o), (exp_dm && dwe) ? 32'(be) : 32'd0);
    if (exp_if || exp_dm) check({name, "/ram_addr"}, 32'(ram_addr_o), 32'(exp_addr));
    if (exp_dm && dwe) check({name, "/ram_wdata"}, ram_wdata_o, wd);
    r.data = exp_rd;
    r.due  = cyc + 1;
    if (exp_if) if_q.push_back(r);
    if (exp_dm && !dwe) dm_q.push_back(r);
    $display("cycle %0d %s: if_gnt=%b dm_gnt=%b ram_en=%b ram_we=%b ram_addr=%h",
             cyc, name, if_gnt_o, dm_gnt_o, ram_en_o, ram_we_o, ram_addr_o);
  endtask

  task automatic idle();
    issue("idle", 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 30'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[0]    = 32'h0000_0011;
    mem[1]    = 32'h0000_0022;
    mem[2]    = 32'h0000_0033;
    mem[8'h10] = 32'hDEAD_0010;

    // Reset with both requesters asserting: everything held at zero.
    if_req_i = 1'b1; if_addr_i = 32'h44;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hF; dm_addr_i = 32'h48; dm_wdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); @(posedge clk_i); #1;
    check("rst/if_gnt", 32'(if_gnt_o), 32'd0);
    check("rst/dm_gnt", 32'(dm_gnt_o), 32'd0);
    check("rst/ram_en", 32'(ram_en_o), 32'd0);
    check("rst/ram_we", 32'(ram_we_o), 32'd0);
    check("rst/if_rvalid", 32'(if_rvalid_o), 32'd0);
    check("rst/dm_rvalid", 32'(dm_rvalid_o), 32'd0);
    check("rst/ram_addr", 32'(ram_addr_o), 32'd0);
    check("rst/ram_wdata", ram_wdata_o, 32'd0);
    check("rst/if_rdata", if_rdata_o, 32'd0);
    check("rst/dm_rdata", dm_rdata_o, 32'd0);
    $display("cycle %0d reset phase done", cyc);
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0;
    #2 n_rst = 1'b1;

    // Reset asserted after an IF read is granted but before the edge.
    @(posedge clk_i); #1;
    if_req_i = 1'b1; if_addr_i = 32'h40;
    #1 check("rstmid/if_gnt_before", 32'(if_gnt_o), 32'd1);
    #1 n_rst = 1'b0;
    #1;
    check("rstmid/if_gnt_during", 32'(if_gnt_o), 32'd0);
    check("rstmid/dm_gnt_during", 32'(dm_gnt_o), 32'd0);
    check("rstmid/ram_en_during", 32'(ram_en_o), 32'd0);
    if_req_i = 1'b0;
    @(posedge clk_i); #1;
    check("rstmid/if_rvalid_during", 32'(if_rvalid_o), 32'd0);
    @(posedge clk_i); #3 n_rst = 1'b1;
    @(posedge clk_i); #1;
    check("rstmid/if_rvalid_after", 32'(if_rvalid_o), 32'd0);
    @(posedge clk_i); #1;
    check("rstmid/if_rvalid_after2", 32'(if_rvalid_o), 32'd0);
    $display("cycle %0d reset-mid-read done", cyc);

    // IF-only back-to-back fetches.
    issue("if0", 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 30'd0, 32'h11);
    issue("if4", 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 30'd1, 32'h22);
    issue("if8", 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 30'd2, 32'h33);

    // Simultaneous requests: DM first, IF next cycle.
    issue("sim_dm", 1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 30'h10, 32'hDEAD_0010);
    issue("sim_if", 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 30'h10, 32'hDEAD_0010);

    // Partial write, zero-enable write, then readback.
    issue("wr_half", 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h8, 32'hAABB_CCDD, 1'b0, 1'b1, 30'd2, 32'h0);
    issue("rd_half", 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b0, 1'b1, 30'd2, 32'h0000_CCDD);
    issue("wr_be0", 1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h8, 32'hFFFF_FFFF, 1'b0, 1'b1, 30'd2, 32'h0);
    issue("rd_be0", 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b0, 1'b1, 30'd2, 32'h0000_CCDD);

    // Starvation: DM four times, IF forced on the fifth, repeating.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4)
        issue("starve_if", 1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 30'd1, 32'h22);
      else
        issue("starve_dm", 1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 30'd0, 32'h11);
    end

    // IF drops its request in the forced slot: nobody is granted.
    for (int i = 0; i < 4; i++)
      issue("drop_dm", 1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 30'd0, 32'h11);
    issue("drop_none", 1'b0, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 30'd0, 32'h0);
    issue("drop_resume", 1'b0, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 30'd0, 32'h11);

    // Back-to-back mixed reads.
    issue("b2b_dm", 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 30'd0, 32'h11);
    issue("b2b_if", 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 30'd1, 32'h22);
    idle();
    idle();
    idle();

    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("dm_q_drained", 32'(dm_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
